// File: rtl/cpu_bus_pkg.sv
// Shared FSM type and constants for cpu_bus_adapter and its helpers.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    StRun,
    StWait,
    StHalt
  } state_e;

  localparam logic BusWeNRst   = 1'b1;
  localparam logic BusAbRstBit = 1'b0;

  // Wait-state counter holds 0..15.
  localparam int unsigned WsW = $clog2(16);

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser (preset inactive-high) with a registered falling-edge pulse.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign fall_o  = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/cpu_bus_adapter.sv
// CPU-to-system-bus adapter: ce divider, registered bus stage, wait states, IRQ/NMI sync.
// Defining CPU_BUS_ADAPTER_BREAKPOINT_EN adds the breakpoint ports and the HALT state.
module cpu_bus_adapter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned   AW          = 16,
  parameter int unsigned   DW          = 8,
  parameter int unsigned   CE_DIV      = 4,
  parameter int unsigned   WAIT_STATES = 0,
  parameter logic [AW-1:0] SLOW_MASK   = AW'(16'hF000),
  parameter logic [AW-1:0] SLOW_BASE   = AW'(16'h8000),
  parameter int unsigned   SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] core_ab,
  input  logic [DW-1:0] core_do,
  input  logic          core_we,
  output logic          core_ce,
  output logic          core_rdy,
  output logic          core_irq,
  output logic          core_nmi,
  output logic [AW-1:0] bus_ab,
  output logic [DW-1:0] bus_do,
  output logic          bus_we_n,
  input  logic          bus_rdy,
`ifdef CPU_BUS_ADAPTER_BREAKPOINT_EN
  input  logic [AW-1:0] bp_addr,
  input  logic          bp_arm,
  input  logic          bp_resume,
  output logic          bp_hit,
`endif
  input  logic          irq_n,
  input  logic          nmi_n
);

  localparam int unsigned     DivW    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CE_DIV - 1);

  logic [DivW-1:0] div_q, div_d;
  logic            div_last;
  logic            core_ce_q, core_rdy_q, core_nmi_q, core_nmi_d;
  logic            tick, slow_hit;
  state_e          state_q, state_d;
  logic [WsW-1:0]  ws_q, ws_d, ws_dec;
  logic [AW-1:0]   bus_ab_q, bus_ab_d;
  logic [DW-1:0]   bus_do_q, bus_do_d;
  logic            bus_we_n_q, bus_we_n_d;
  logic            irq_level, nmi_fall;
  logic            unused_irq_fall, unused_nmi_level;

  assign div_last = (div_q == DivLast);
  assign div_d    = div_last ? '0 : div_q + 1'b1;
  assign tick     = core_ce_q;
  assign slow_hit = ((core_ab & SLOW_MASK) == SLOW_BASE) && (WAIT_STATES > 0);
  assign ws_dec   = (ws_q == '0) ? '0 : ws_q - 1'b1;

  sync_edge #(
    .STAGES(SYNC_STAGES)
  ) u_irq_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .d_i    (irq_n),
    .level_o(irq_level),
    .fall_o (unused_irq_fall)
  );

  sync_edge #(
    .STAGES(SYNC_STAGES)
  ) u_nmi_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .d_i    (nmi_n),
    .level_o(unused_nmi_level),
    .fall_o (nmi_fall)
  );

  // A new edge beats the clear so a request arriving as the core samples is not lost.
  assign core_nmi_d = nmi_fall | (core_nmi_q & ~(core_ce_q & core_rdy_q));

`ifdef CPU_BUS_ADAPTER_BREAKPOINT_EN
  logic bp_hit_q;
  logic resume_q, resume_d;
`endif

  always_comb begin
    state_d    = state_q;
    ws_d       = ws_q;
    bus_ab_d   = bus_ab_q;
    bus_do_d   = bus_do_q;
    bus_we_n_d = bus_we_n_q;
`ifdef CPU_BUS_ADAPTER_BREAKPOINT_EN
    resume_d   = resume_q;
`endif
    unique case (state_q)
      StRun: begin
        if (tick) begin
          bus_ab_d   = core_ab;
          bus_do_d   = core_do;
          bus_we_n_d = ~core_we;
          if (slow_hit) begin
            ws_d    = WsW'(WAIT_STATES);
            state_d = StWait;
          end
        end
        if (!bus_rdy) state_d = StWait;
`ifdef CPU_BUS_ADAPTER_BREAKPOINT_EN
        resume_d = 1'b0;
        if (tick && bp_arm && (core_ab == bp_addr)) state_d = StHalt;
`endif
      end
      StWait: begin
        // Leave on the tick that drains the count: a slow access spans WAIT_STATES+1 ticks.
        if (tick) begin
          ws_d = ws_dec;
          if ((ws_dec == '0) && bus_rdy) state_d = StRun;
        end
      end
`ifdef CPU_BUS_ADAPTER_BREAKPOINT_EN
      StHalt: begin
        if (bp_resume) resume_d = 1'b1;
        if (tick) begin
          ws_d = ws_dec;
          if (resume_q || bp_resume) begin
            resume_d = 1'b0;
            state_d  = ((ws_dec == '0) && bus_rdy) ? StRun : StWait;
          end
        end
      end
`endif
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      core_ce_q  <= 1'b0;
      core_rdy_q <= 1'b1;
      core_nmi_q <= 1'b0;
      state_q    <= StRun;
      ws_q       <= '0;
      bus_ab_q   <= {AW{BusAbRstBit}};
      bus_do_q   <= '0;
      bus_we_n_q <= BusWeNRst;
    end else begin
      div_q      <= div_d;
      core_ce_q  <= div_last;
      core_rdy_q <= (state_d == StRun);
      core_nmi_q <= core_nmi_d;
      state_q    <= state_d;
      ws_q       <= ws_d;
      bus_ab_q   <= bus_ab_d;
      bus_do_q   <= bus_do_d;
      bus_we_n_q <= bus_we_n_d;
    end
  end

`ifdef CPU_BUS_ADAPTER_BREAKPOINT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bp_hit_q <= 1'b0;
      resume_q <= 1'b0;
    end else begin
      bp_hit_q <= (state_d == StHalt);
      resume_q <= resume_d;
    end
  end

  assign bp_hit = bp_hit_q;
`endif

  assign core_ce  = core_ce_q;
  assign core_rdy = core_rdy_q;
  assign core_irq = ~irq_level;
  assign core_nmi = core_nmi_q;
  assign bus_ab   = bus_ab_q;
  assign bus_do   = bus_do_q;
  assign bus_we_n = bus_we_n_q;

endmodule

// File: tb/tb_cpu_bus_adapter.sv
// Scoreboard bench for cpu_bus_adapter (CE_DIV=4, WAIT_STATES=2, SYNC_STAGES=2).
module tb_cpu_bus_adapter;

  logic        clk, rst;
  logic [15:0] core_ab;
  logic [7:0]  core_do;
  logic        core_we, core_ce, core_rdy, core_irq, core_nmi;
  logic [15:0] bus_ab;
  logic [7:0]  bus_do;
  logic        bus_we_n, bus_rdy, irq_n, nmi_n;
`ifdef CPU_BUS_ADAPTER_BREAKPOINT_EN
  logic [15:0] bp_addr;
  logic        bp_arm, bp_resume, bp_hit;
`endif

  int          n_checks = 0;
  int          n_err    = 0;
  logic [24:0] exp_q[$];
  logic [24:0] mon_prev, mon_cur;
  logic [15:0] last_ab = 16'h0000;
  int          waited, stalled;

  cpu_bus_adapter #(
    .AW(16), .DW(8), .CE_DIV(4), .WAIT_STATES(2),
    .SLOW_MASK(16'hF000), .SLOW_BASE(16'h8000), .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .core_ab (core_ab),
    .core_do (core_do),
    .core_we (core_we),
    .core_ce (core_ce),
    .core_rdy(core_rdy),
    .core_irq(core_irq),
    .core_nmi(core_nmi),
    .bus_ab  (bus_ab),
    .bus_do  (bus_do),
    .bus_we_n(bus_we_n),
    .bus_rdy (bus_rdy),
`ifdef CPU_BUS_ADAPTER_BREAKPOINT_EN
    .bp_addr  (bp_addr),
    .bp_arm   (bp_arm),
    .bp_resume(bp_resume),
    .bp_hit   (bp_hit),
`endif
    .irq_n   (irq_n),
    .nmi_n   (nmi_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: condition not reached within bound, required within 100 clocks", name);
  endtask

  // Present one core access, queue its expected bus image, hold until the core handshake.
  task automatic issue(input logic [15:0] ab, input logic [7:0] dat, input logic we,
                       output int w, output int s);
    w = 0;
    s = 0;
    core_ab = ab;
    core_do = dat;
    core_we = we;
    exp_q.push_back({ab, dat, ~we});
    while (!(core_ce && core_rdy) && w < 100) begin
      if (!core_rdy) s++;
      @(negedge clk);
      w++;
    end
    if (w >= 100) timeout("handshake");
    check("bus_hold", bus_ab, last_ab);
    @(negedge clk);
    last_ab = ab;
  endtask

  task automatic wait_hs();
    int n = 0;
    while (!(core_ce && core_rdy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout("wait_handshake");
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!core_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout("wait_rdy");
  endtask

  // Monitor: every bus-register change outside reset is one bus cycle to score.
  always @(posedge clk) begin
    #1;
    mon_cur = {bus_ab, bus_do, bus_we_n};
    if (!rst && (mon_cur !== mon_prev)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL bus_cycle: got %h, expected no bus cycle", mon_cur);
      end else begin
        check("bus_cycle", {7'd0, mon_cur}, {7'd0, exp_q.pop_front()});
      end
    end
    mon_prev = mon_cur;
  end

  initial begin
    rst = 1'b1;
    core_ab = '0;
    core_do = '0;
    core_we = 1'b0;
    bus_rdy = 1'b1;
    irq_n = 1'b1;
    nmi_n = 1'b1;
`ifdef CPU_BUS_ADAPTER_BREAKPOINT_EN
    bp_addr = 16'hC000;
    bp_arm = 1'b0;
    bp_resume = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_bus_we_n", bus_we_n, 1'b1);
    check("rst_bus_ab", bus_ab, 16'h0000);
    check("rst_bus_do", bus_do, 8'h00);
    check("rst_core_rdy", core_rdy, 1'b1);
    check("rst_core_ce", core_ce, 1'b0);
    check("rst_core_irq", core_irq, 1'b0);
    check("rst_core_nmi", core_nmi, 1'b0);

    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      check("ce_period", core_ce, (i % 4 == 0));
    end

    // Write, slow read, then fast accesses.
    issue(16'h1234, 8'hA5, 1'b1, waited, stalled);
    check("first_accept_wait", waited, 0);
    issue(16'h8010, 8'h3C, 1'b0, waited, stalled);
    check("fast_wait", waited, 3);
    issue(16'h4000, 8'h5A, 1'b1, waited, stalled);
    check("slow_wait", waited, 11);
    check("slow_stall_clks", stalled, 8);
    issue(16'h4004, 8'h66, 1'b0, waited, stalled);
    check("fast_after_fast_wait", waited, 3);
    check("fast_stall_clks", stalled, 0);

    // bus_rdy low for 9 clocks during a fast access.
    fork
      begin
        bus_rdy = 1'b0;
        repeat (9) @(negedge clk);
        bus_rdy = 1'b1;
      end
    join_none
    issue(16'h2008, 8'h81, 1'b1, waited, stalled);
    check("busrdy_wait", waited, 15);
    check("busrdy_stall_clks", stalled, 11);

    // Reset pulse in the middle of an extended cycle.
    bus_rdy = 1'b0;
    repeat (5) @(negedge clk);
    check("midwait_rdy", core_rdy, 1'b0);
    rst = 1'b1;
    core_ab = '0;
    core_do = '0;
    core_we = 1'b0;
    @(negedge clk);
    check("midrst_core_rdy", core_rdy, 1'b1);
    check("midrst_bus_ab", bus_ab, 16'h0000);
    check("midrst_bus_we_n", bus_we_n, 1'b1);
    check("midrst_core_ce", core_ce, 1'b0);
    rst = 1'b0;
    bus_rdy = 1'b1;
    last_ab = 16'h0000;
    issue(16'h3000, 8'h0F, 1'b1, waited, stalled);

    // IRQ synchroniser latency.
    irq_n = 1'b0;
    @(negedge clk);
    check("irq_lat1", core_irq, 1'b0);
    @(negedge clk);
    check("irq_lat2", core_irq, 1'b1);
    irq_n = 1'b1;
    repeat (2) @(negedge clk);
    check("irq_release", core_irq, 1'b0);

    // NMI edge, latency and clear.
    nmi_n = 1'b0;
    repeat (2) @(negedge clk);
    check("nmi_lat2", core_nmi, 1'b0);
    @(negedge clk);
    check("nmi_lat3", core_nmi, 1'b1);
    nmi_n = 1'b1;
    wait_hs();
    @(negedge clk);
    check("nmi_clear", core_nmi, 1'b0);

    // NMI edge landing on the clearing ce: set must win.
    bus_rdy = 1'b0;
    repeat (2) @(negedge clk);
    nmi_n = 1'b0;
    repeat (3) @(negedge clk);
    check("nmi_pending_stalled", core_nmi, 1'b1);
    nmi_n = 1'b1;
    repeat (3) @(negedge clk);
    bus_rdy = 1'b1;
    wait_rdy();
    @(negedge clk);
    nmi_n = 1'b0;
    repeat (2) @(negedge clk);
    check("nmi_clear_ce", {core_ce, core_rdy}, 2'b11);
    check("nmi_before_clear", core_nmi, 1'b1);
    @(negedge clk);
    check("nmi_set_wins", core_nmi, 1'b1);
    nmi_n = 1'b1;
    wait_hs();
    @(negedge clk);
    check("nmi_final_clear", core_nmi, 1'b0);

`ifdef CPU_BUS_ADAPTER_BREAKPOINT_EN
    bp_arm = 1'b1;
    issue(16'hC000, 8'h77, 1'b0, waited, stalled);
    check("bp_hit", bp_hit, 1'b1);
    check("bp_rdy", core_rdy, 1'b0);
    bp_arm = 1'b0;
    bp_resume = 1'b1;
    @(negedge clk);
    bp_resume = 1'b0;
    wait_rdy();
    check("bp_resume_rdy", core_rdy, 1'b1);
    check("bp_hit_clear", bp_hit, 1'b0);
`endif

    repeat (4) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_bus_adapter.md
Name: cpu_bus_adapter

Overview:
- Parametrised successor to the single-CPU bus register stage.
- Sits between a soft CPU core and the board/system bus.
- Generates the CPU clock-enable strobe from a divider and registers address, data and write on each accepted bus cycle.
- Inserts programmable wait states for a slow address region, honours external bus ready, and synchronises IRQ/NMI with NMI edge latching.

Parameters:
- AW, 16, address width
- DW, 8, data width
- CE_DIV, 4, clocks per CPU enable strobe (>=1; 1 = strobe every clock)
- WAIT_STATES, 0, extra ce periods inserted for slow-region accesses (0..15)
- SLOW_MASK, 16'hF000, address mask selecting the slow-region compare bits
- SLOW_BASE, 16'h8000, slow-region match value after masking
- SYNC_STAGES, 2, flops in the IRQ/NMI synchronisers (>=2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- core_ab  in  AW  core address (combinational from core)
- core_do  in  DW  core write data
- core_we  in  1  core write, active high
- core_ce  out  1  one-clock enable strobe to core
- core_rdy  out  1  ready to core; 0 stalls the core
- core_irq  out  1  synchronised IRQ level, active high
- core_nmi  out  1  latched NMI request, active high
- bus_ab  out  AW  registered bus address
- bus_do  out  DW  registered bus write data
- bus_we_n  out  1  registered write, active low
- bus_rdy  in  1  external ready; 0 extends the current cycle
- irq_n  in  1  async IRQ, active low level
- nmi_n  in  1  async NMI, active low, falling-edge sensitive

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst at posedge clk. All outputs are registered.
- Reset values:
  - Outputs: core_ce=0, core_rdy=1, core_irq=0, core_nmi=0, bus_ab=0, bus_do=0, bus_we_n=1.
  - Internal: divider=0, ws_cnt=0, FSM=RUN. Synchroniser flops preset to 1 (inactive).
- Divider:
  - Counts 0..CE_DIV-1 and wraps.
  - core_ce=1 for exactly the clock after the count reaches CE_DIV-1, giving period CE_DIV.
  - Free-running; never gated by stalls.
- FSM states RUN, WAIT (HALT is added by the optional feature).
  - RUN, tick (divider wrap) with core_rdy=1:
    - Latch bus_ab<=core_ab, bus_do<=core_do, bus_we_n<=~core_we.
    - If (core_ab & SLOW_MASK)==SLOW_BASE and WAIT_STATES>0: ws_cnt<=WAIT_STATES, go WAIT.
  - RUN with bus_rdy=0 sampled: go WAIT.
  - WAIT:
    - core_rdy=0.
    - ws_cnt decrements on each tick, saturating at 0.
    - Bus registers hold.
    - Exit to RUN on the tick where ws_cnt==0 and bus_rdy=1. core_rdy=1 from the following clock.
  - Bus registers never change while core_rdy=0.
- Latency: bus outputs change 1 clk after the tick that accepts the cycle. Slow access = WAIT_STATES+1 ce periods.
- IRQ: SYNC_STAGES-flop synchroniser; core_irq = ~synced level. Latency SYNC_STAGES clks.
- NMI:
  - Synchronised falling edge sets core_nmi.
  - Cleared on the next ce with core_rdy=1 (core has sampled it).
  - Edge and clear in the same clock: set wins.
  - Edges while pending are merged.
- Reset asserted mid-cycle or mid-wait: abandon the cycle and apply reset values next clock.

Optional Feature:
- Macro: CPU_BUS_ADAPTER_BREAKPOINT_EN.
- Defined:
  - Adds ports bp_addr in AW, bp_arm in 1, bp_resume in 1, bp_hit out 1.
  - Armed and a RUN tick accepts core_ab==bp_addr: bus cycle is latched normally, then go HALT with core_rdy=0 and bp_hit=1.
  - bp_resume pulse returns to RUN on the next tick and clears bp_hit. Resume during a wait period goes to WAIT.
  - Reset clears HALT and bp_hit.
- Undefined: no extra ports, no HALT state, behaviour as above.

Decomposition:
- Package cpu_bus_pkg:
  - FSM state enum (RUN, WAIT, HALT).
  - Reset constants for bus_we_n/bus_ab.
  - Width of ws_cnt, computed as clog2(16).
- Sub-module sync_edge (parameter STAGES): synchroniser with a falling-edge pulse output. Instanced for IRQ (level used) and NMI (edge used).

Test Plan:
- CE_DIV=4, reset released: core_ce pulses every 4th clk. During reset bus_we_n=1, bus_ab=0, core_rdy=1.
- Core write 16'h1234/8'hA5 on tick: next clk bus_ab=16'h1234, bus_do=8'hA5, bus_we_n=0; holds until next tick.
- WAIT_STATES=2, access 16'h8010: core_rdy low for 2 ce periods, bus_ab held at 16'h8010. Access 16'h4000 incurs no stall.
- bus_rdy=0 for 9 clks during a fast access: core_rdy=0 throughout, exit on first tick after bus_rdy=1; rst pulse mid-wait restores reset values.
- nmi_n falls: core_nmi=1 after 2+1 clks, cleared at next ce with core_rdy=1; second fall coincident with clear keeps core_nmi=1.
- BREAKPOINT_EN, bp_addr=16'hC000 armed: fetch at C000 → bp_hit=1, core_rdy=0. bp_resume → RUN next tick.
